fire_alarm_ctrl: RTL

Multi-zone fire alarm controller; parametrised successor to the single-sensor fire block. Debounces N independent zone sensors, latches confirmed zones, and drives one siren output (f_alarm). Supports operator acknowledge/silence with timed re-sound, clear, and lamp/siren test. Sits between the raw sensor inputs and the building annunciator/siren driver.

---
 rtl/fire_alarm_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fire_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fire_alarm_ctrl
// Description : Multi-zone fire alarm controller. Debounces N_ZONES raw
//               sensor inputs, latches confirmed zones (sticky until cleared
//               with the sensor low), and drives a single siren output.
//               Operator acknowledge silences the siren for SILENCE_CYC
//               cycles; a new fire or the timeout re-sounds it. A test
//               request sounds the siren while no fire is latched.
//
// Ports       : clk           system clock, rising edge
//               rst_n         synchronous active-low reset
//               f_sensor      raw zone sensor levels, 1 = fire
//               ack           operator acknowledge / silence request
//               clear         operator clear of latched zones
//               test          siren test request
//               f_alarm       siren drive, 1 = sounding
//               zone_latched  confirmed zones, sticky
//               alarm_active  any zone latched (ALARM or SILENCED)
//               silenced      siren silenced by operator
//
// Revision    : 1.0 - initial release
// ============================================================================
module fire_alarm_ctrl #(
    parameter int N_ZONES     = 4,
    parameter int DEBOUNCE    = 4,
    parameter int DB_W        = 4,
    parameter int SILENCE_CYC = 16,
    parameter int SIL_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] f_sensor,
    input  logic               ack,
    input  logic               clear,
    input  logic               test,
    output logic               f_alarm,
    output logic [N_ZONES-1:0] zone_latched,
    output logic               alarm_active,
    output logic               silenced
);

    localparam logic [DB_W-1:0]  c_db_max   = DB_W'(DEBOUNCE - 1);
    localparam logic [SIL_W-1:0] c_sil_load = SIL_W'(SILENCE_CYC);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ALARM    = 2'd1,
        ST_SILENCED = 2'd2,
        ST_TEST     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SIL_W-1:0]   r_sil_cnt;
    logic [SIL_W-1:0]   w_sil_next;
    logic [SIL_W-1:0]   w_sil_dec;
    logic [N_ZONES-1:0] r_latched;
    logic [N_ZONES-1:0] w_latch_next;
    logic [N_ZONES-1:0] w_set;
    logic               w_any_latched;
    logic               w_new_fire;
    logic               r_f_alarm;
    logic               r_alarm_active;
    logic               r_silenced;

    // ------------------------------------------------------------------
    // Per-zone debounce and latch. The counter saturates one short of
    // DEBOUNCE; the sample that finds it saturated with the sensor still
    // high is the DEBOUNCE-th consecutive high sample and sets the latch.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_ZONES; gi++) begin : g_zone
            logic [DB_W-1:0] r_db_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_db_cnt <= '0;
                end else if (!f_sensor[gi]) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt != c_db_max) begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end

            assign w_set[gi] = f_sensor[gi] && (r_db_cnt == c_db_max);

            // A latch event in the same cycle as clear keeps the bit set;
            // clear only drops a zone whose sensor is currently low.
            assign w_latch_next[gi] = w_set[gi] |
                                      (r_latched[gi] & ~(clear & ~f_sensor[gi]));
        end
    endgenerate

    assign w_any_latched = |w_latch_next;
    assign w_new_fire    = |(w_latch_next & ~r_latched);
    assign w_sil_dec     = (r_sil_cnt != '0) ? (r_sil_cnt - SIL_W'(1)) : '0;

    // ------------------------------------------------------------------
    // State register, latch register and registered Moore outputs.
    // Outputs decode the state register, so they trail a transition by
    // one cycle (siren sounds the cycle after the zone latches).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_sil_cnt      <= '0;
            r_latched      <= '0;
            r_f_alarm      <= 1'b0;
            r_alarm_active <= 1'b0;
            r_silenced     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_sil_cnt      <= w_sil_next;
            r_latched      <= w_latch_next;
            r_f_alarm      <= (r_state == ST_ALARM) || (r_state == ST_TEST);
            r_alarm_active <= (r_state == ST_ALARM) || (r_state == ST_SILENCED);
            r_silenced     <= (r_state == ST_SILENCED);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Transitions look at the latch value being written
    // on this edge, so a clear that empties the latches is seen at once.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_sil_next   = r_sil_cnt;

        case (r_state)
            ST_IDLE: begin
                w_sil_next = '0;
                if (w_any_latched) begin
                    w_state_next = ST_ALARM;
                end else if (test) begin
                    w_state_next = ST_TEST;
                end
            end

            ST_ALARM: begin
                w_sil_next = '0;
                // Clear is evaluated before ack; ack only silences if
                // zones survive the clear.
                if (clear && !w_any_latched) begin
                    w_state_next = ST_IDLE;
                end else if (ack) begin
                    w_state_next = ST_SILENCED;
                    w_sil_next   = c_sil_load;
                end
            end

            ST_SILENCED: begin
                // ack is deliberately ignored here: no reload of the timer.
                if (clear && !w_any_latched) begin
                    w_state_next = ST_IDLE;
                    w_sil_next   = '0;
                end else if (w_new_fire || (w_sil_dec == '0) || clear) begin
                    w_state_next = ST_ALARM;
                    w_sil_next   = '0;
                end else begin
                    w_sil_next   = w_sil_dec;
                end
            end

            ST_TEST: begin
                w_sil_next = '0;
                if (w_any_latched) begin
                    w_state_next = ST_ALARM;
                end else if (!test) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_sil_next   = '0;
            end
        endcase
    end

    assign f_alarm      = r_f_alarm;
    assign zone_latched = r_latched;
    assign alarm_active = r_alarm_active;
    assign silenced     = r_silenced;

endmodule
`default_nettype wire
